// File: rtl/fetch_unit.sv
// Instruction prefetch unit: start->req 1 cycle, start->instr_valid 3 cycles; issue stalls while buffer+in-flight fill DEPTH.
// Valid/ready drain at one instr per cycle; define FETCH_UNIT_PERF_CNT_EN to add the fetch_cnt transfer counter.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               stop,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               waiting
`ifdef FETCH_UNIT_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     fl_pc;
    logic                fl_vld;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [AW:0]         count;
    logic [INSTR_W-1:0]  buf_instr [DEPTH];
    logic [PC_W-1:0]     buf_pc [DEPTH];

    logic                running;
    logic                hold;
    logic [CW-1:0]       occ;
    logic                issue;
    logic                push;
    logic                pop;

    // A redirect/stop cycle suppresses issue, delivery and the in-flight write.
    assign running     = (state == RUN) && !rst;
    assign hold        = redirect || stop;
    assign occ         = CW'(count) + CW'(fl_vld);
    assign issue       = running && !hold && (occ < CW'(DEPTH));
    assign push        = running && !hold && fl_vld;
    assign instr_valid = running && !hold && (count != '0);
    assign pop         = instr_valid && instr_ready;

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign instr_out   = buf_instr[head];
    assign instr_pc    = buf_pc[head];
    assign waiting     = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            fl_pc  <= '0;
            fl_vld <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fl_vld <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        pc    <= start_pc;
                    end
                end
                RUN: begin
                    if (stop || redirect) begin
                        fl_vld <= 1'b0;
                        head   <= '0;
                        tail   <= '0;
                        count  <= '0;
                        if (stop) begin
                            state <= IDLE;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else begin
                        fl_vld <= issue;
                        if (issue) begin
                            fl_pc <= pc;
                            pc    <= pc + PC_W'(1);
                        end
                        if (push) begin
                            tail <= tail + AW'(1);
                        end
                        if (pop) begin
                            head <= head + AW'(1);
                        end
                        case ({push, pop})
                            2'b10:   count <= count + (AW+1)'(1);
                            2'b01:   count <= count - (AW+1)'(1);
                            default: count <= count;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= imem_rdata;
            buf_pc[tail]    <= fl_pc;
        end
    end

`ifdef FETCH_UNIT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            fetch_cnt <= '0;
        end else if (pop && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch-buffer entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 start  input  1  pulse; in IDLE, load start_pc and begin fetching.
REQ-007 start_pc  input  PC_W  first fetch address.
REQ-008 stop  input  1  pulse; flush and return to IDLE.
REQ-009 redirect  input  1  pulse; branch; flush and refetch from redirect_pc.
REQ-010 redirect_pc  input  PC_W  branch target.
REQ-011 imem_req  output  1  memory read strobe.
REQ-012 imem_addr  output  PC_W  memory read address.
REQ-013 imem_rdata  input  INSTR_W  read data, valid exactly one cycle after imem_req.
REQ-014 instr_out  output  INSTR_W  head-of-buffer instruction.
REQ-015 instr_pc  output  PC_W  address instr_out was fetched from.
REQ-016 instr_valid  output  1  instr_out/instr_pc valid.
REQ-017 instr_ready  input  1  consumer accepts; transfer when instr_valid and instr_ready are both high.
REQ-018 waiting  output  1  high in IDLE.

Function
REQ-019 SHALL implement two states: IDLE and RUN.
REQ-020 IDLE: imem_req=0, instr_valid=0, waiting=1; start moves to RUN with pc<=start_pc; redirect and stop ignored.
REQ-021 RUN: imem_req=1 and imem_addr=pc when (buffer count + in-flight) < DEPTH and no redirect/stop this cycle; each issue advances pc by 1, wrapping modulo 2^PC_W.
REQ-022 Issued request SHALL write {imem_rdata, issuing pc} into buffer the following cycle unless discarded (REQ-025).
REQ-023 Buffer FIFO-ordered; instr_out/instr_pc from head; instr_valid = (count>0) and no redirect/stop this cycle.
REQ-024 Simultaneous write and transfer SHALL leave count unchanged; no overflow possible by REQ-021; transfer when empty impossible.
REQ-025 redirect in RUN: buffer emptied, in-flight response discarded, pc<=redirect_pc; first new request issued next cycle.
REQ-026 stop in RUN: buffer emptied, in-flight response discarded, go to IDLE; stop wins over simultaneous redirect.
REQ-027 start in RUN SHALL be ignored.
REQ-028 Latency: start at cycle 0 -> first imem_req at cycle 1 -> instr_valid at cycle 3.
REQ-029 Consumer holding instr_ready=1 with memory never stalling SHALL receive one instruction per cycle sustained.

Reset
REQ-030 rst SHALL force: state IDLE, pc=0, buffer count 0, in-flight cleared, imem_req=0, imem_addr=0, instr_valid=0, waiting=1.
REQ-031 rst SHALL override every other input in the same cycle, including mid-RUN with full buffer and a request in flight; the in-flight response is discarded.

Configuration
REQ-032 Macro FETCH_UNIT_PERF_CNT_EN defined: output fetch_cnt (16 bits) counts accepted transfers, saturates at 16'hFFFF, cleared by rst and by start in IDLE.
REQ-033 Macro undefined: fetch_cnt port and counter absent; all other behaviour identical.

Verification
REQ-034 rst, start=1 start_pc=8'h10, instr_ready=1, mem returns addr+16'h100 -> instr_valid from cycle 3; instr_out 16'h0110,16'h0111,... one per cycle; instr_pc 10,11,...
REQ-035 instr_ready=0 after start -> exactly 4 requests (addr 10..13), then imem_req=0; raising instr_ready resumes fetch at addr 14 in order.
REQ-036 redirect=1 redirect_pc=8'h40 with full buffer and request in flight -> instr_valid=0 next cycle; next imem_addr=40; first delivered instr_pc=40, no stale entries.
REQ-037 start_pc=8'hFE -> instr_pc sequence FE, FF, 00, 01.
REQ-038 rst asserted mid-RUN with full buffer -> next cycle waiting=1, instr_valid=0, imem_req=0; late imem_rdata ignored; a new start fetches correctly.
REQ-039 With FETCH_UNIT_PERF_CNT_EN defined: 5 accepted transfers -> fetch_cnt=5; stop then start -> fetch_cnt=0.
